// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, addresses instruction memory and
// captures the fetched word into the IF/ID register, honouring freeze and branch flush.
module if_stage #(
    parameter int unsigned         ADDR_W   = 32,
    parameter logic [ADDR_W-1:0]   RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              freeze,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_addr,
    output logic [ADDR_W-1:0] instru_addr,
    input  logic [31:0]       instru_in,
    output logic [ADDR_W-1:0] id_pc,
    output logic [31:0]       id_instru,
    output logic              id_valid
);

    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_plus4;
    logic [ADDR_W-1:0] branch_target;
    logic [ADDR_W-1:0] pc_next;

    assign pc_plus4      = pc + ADDR_W'(4);
    assign branch_target = {branch_addr[ADDR_W-1:2], 2'b00};

    // Branch outranks freeze: a resolved branch must never be lost to a stall.
    always_comb begin
        pc_next = pc_plus4;
        if (branch_taken) begin
            pc_next = branch_target;
        end else if (freeze) begin
            pc_next = pc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc <= RESET_PC;
        end else begin
            pc <= pc_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            id_instru <= 32'b0;
            id_pc     <= '0;
            id_valid  <= 1'b0;
        end else if (branch_taken) begin
            id_instru <= 32'b0;
            id_pc     <= '0;
            id_valid  <= 1'b0;
        end else if (!freeze) begin
            id_instru <= instru_in;
            id_pc     <= pc_plus4;
            id_valid  <= 1'b1;
        end
    end

    // Memory address comes straight from the PC flop, never from an input.
    assign instru_addr = pc;

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed scenarios plus randomized freeze/branch traffic
// checked against a simple fetch model.
module tb_if_stage;

    localparam int AW = 32;

    logic          clk;
    logic          rst;
    logic          freeze;
    logic          branch_taken;
    logic [AW-1:0] branch_addr;
    logic [AW-1:0] instru_addr;
    logic [31:0]   instru_in;
    logic [AW-1:0] id_pc;
    logic [31:0]   id_instru;
    logic          id_valid;

    int n_cmp;
    int n_err;

    // 128-word instruction memory at 0x000..0x1FC; everything else reads 0.
    logic [31:0] mem [0:127];

    // Reference state: what the PC and IF/ID should hold.
    logic [AW-1:0] m_pc;
    logic [AW-1:0] m_ip;
    logic [31:0]   m_ii;
    logic          m_iv;

    logic [96:0] exp_v;
    logic [96:0] act_v;

    if_stage #(.ADDR_W(AW), .RESET_PC(32'd0)) dut (
        .clk(clk),
        .rst(rst),
        .freeze(freeze),
        .branch_taken(branch_taken),
        .branch_addr(branch_addr),
        .instru_addr(instru_addr),
        .instru_in(instru_in),
        .id_pc(id_pc),
        .id_instru(id_instru),
        .id_valid(id_valid)
    );

    assign instru_in = (instru_addr < 32'h200) ? mem[instru_addr[8:2]] : 32'h0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    function automatic logic [31:0] ref_mem(input logic [AW-1:0] a);
        if (a < 32'h200) return mem[a / 4];
        return 32'h0;
    endfunction

    task automatic model_reset();
        m_pc = 32'd0;
        m_ip = 32'd0;
        m_ii = 32'd0;
        m_iv = 1'b0;
    endtask

    task automatic model_edge(input bit f, input bit b, input logic [AW-1:0] ba);
        if (b) begin
            m_pc = ba - (ba % 4);
            m_ii = 32'd0;
            m_ip = 32'd0;
            m_iv = 1'b0;
        end else if (!f) begin
            m_ii = ref_mem(m_pc);
            m_ip = m_pc + 32'd4;
            m_iv = 1'b1;
            m_pc = m_pc + 32'd4;
        end
    endtask

    // Apply inputs, take one edge, advance the model, settle 1 time unit past the edge.
    task automatic drive_edge(input bit f, input bit b, input logic [AW-1:0] ba);
        freeze       = f;
        branch_taken = b;
        branch_addr  = ba;
        @(posedge clk);
        model_edge(f, b, ba);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #3;
        model_reset();
        exp_v = {m_pc, m_ip, m_ii, m_iv};
        act_v = {instru_addr, id_pc, id_instru, id_valid};
        n_cmp++;
        if (act_v !== exp_v) begin
            n_err++;
            $display("FAIL reset_state: got %h expected %h", act_v, exp_v);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_run();
        drive_edge(0, 0, 0);
        n_cmp++;
        if ({id_instru, id_pc, instru_addr, id_valid} !== {32'hE3A00B01, 32'd4, 32'd4, 1'b1}) begin
            n_err++;
            $display("FAIL run_edge1: got instr=%h pc=%h addr=%h v=%b expected E3A00B01/4/4/1",
                     id_instru, id_pc, instru_addr, id_valid);
        end
        drive_edge(0, 0, 0);
        n_cmp++;
        if ({id_instru, id_pc, instru_addr} !== {32'hE3A01A01, 32'd8, 32'd8}) begin
            n_err++;
            $display("FAIL run_edge2: got instr=%h pc=%h addr=%h expected E3A01A01/8/8",
                     id_instru, id_pc, instru_addr);
        end
        drive_edge(0, 0, 0);
        exp_v = {m_pc, m_ip, m_ii, m_iv};
        act_v = {instru_addr, id_pc, id_instru, id_valid};
        n_cmp++;
        if (act_v !== exp_v) begin
            n_err++;
            $display("FAIL run_edge3: got %h expected %h", act_v, exp_v);
        end
    endtask

    task automatic test_freeze();
        logic [31:0] held_ii;
        logic [AW-1:0] held_ip;
        held_ii = m_ii;
        held_ip = m_ip;
        for (int i = 0; i < 3; i++) begin
            drive_edge(1, 0, 0);
            n_cmp++;
            if ({instru_addr, id_pc, id_instru, id_valid} !== {32'd12, held_ip, held_ii, 1'b1}) begin
                n_err++;
                $display("FAIL freeze_hold%0d: got addr=%h pc=%h instr=%h v=%b expected c/%h/%h/1",
                         i, instru_addr, id_pc, id_instru, id_valid, held_ip, held_ii);
            end
        end
        drive_edge(0, 0, 0);
        n_cmp++;
        if ({id_instru, id_pc, instru_addr, id_valid} !== {mem[3], 32'd16, 32'd16, 1'b1}) begin
            n_err++;
            $display("FAIL freeze_release: got instr=%h pc=%h addr=%h expected %h/10/10",
                     id_instru, id_pc, instru_addr, mem[3]);
        end
        drive_edge(0, 0, 0);
    endtask

    task automatic test_branch();
        drive_edge(0, 1, 32'h40);
        n_cmp++;
        if ({instru_addr, id_valid, id_instru, id_pc} !== {32'h40, 1'b0, 32'h0, 32'h0}) begin
            n_err++;
            $display("FAIL branch_flush: got addr=%h v=%b instr=%h pc=%h expected 40/0/0/0",
                     instru_addr, id_valid, id_instru, id_pc);
        end
        drive_edge(0, 0, 0);
        n_cmp++;
        if ({id_instru, id_pc, id_valid} !== {mem[16], 32'h44, 1'b1}) begin
            n_err++;
            $display("FAIL branch_target: got instr=%h pc=%h v=%b expected %h/44/1",
                     id_instru, id_pc, id_valid, mem[16]);
        end
    endtask

    task automatic test_branch_freeze();
        drive_edge(1, 1, 32'h13);
        n_cmp++;
        if ({instru_addr, id_valid, id_instru, id_pc} !== {32'h10, 1'b0, 32'h0, 32'h0}) begin
            n_err++;
            $display("FAIL branch_freeze: got addr=%h v=%b instr=%h pc=%h expected 10/0/0/0",
                     instru_addr, id_valid, id_instru, id_pc);
        end
        drive_edge(0, 0, 0);
    endtask

    task automatic test_wrap();
        drive_edge(0, 1, 32'hFFFFFFFC);
        drive_edge(0, 0, 0);
        n_cmp++;
        if ({instru_addr, id_pc, id_instru, id_valid} !== {32'h0, 32'h0, 32'h0, 1'b1}) begin
            n_err++;
            $display("FAIL wrap: got addr=%h pc=%h instr=%h v=%b expected 0/0/0/1",
                     instru_addr, id_pc, id_instru, id_valid);
        end
    endtask

    task automatic test_async_reset();
        drive_edge(0, 1, 32'h20);
        drive_edge(0, 0, 0);
        freeze = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({instru_addr, id_valid, id_pc, id_instru} !== {32'h0, 1'b0, 32'h0, 32'h0}) begin
            n_err++;
            $display("FAIL async_reset: got addr=%h v=%b pc=%h instr=%h expected 0/0/0/0",
                     instru_addr, id_valid, id_pc, id_instru);
        end
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        drive_edge(0, 0, 0);
        n_cmp++;
        if ({id_instru, id_pc, instru_addr, id_valid} !== {32'hE3A00B01, 32'd4, 32'd4, 1'b1}) begin
            n_err++;
            $display("FAIL reset_restart: got instr=%h pc=%h addr=%h v=%b expected E3A00B01/4/4/1",
                     id_instru, id_pc, instru_addr, id_valid);
        end
    endtask

    task automatic test_random();
        bit f;
        bit b;
        logic [AW-1:0] ba;
        for (int i = 0; i < 400; i++) begin
            f  = ($urandom_range(0, 3) == 0);
            b  = ($urandom_range(0, 7) == 0);
            ba = ($urandom_range(0, 9) == 0) ? $urandom() : 32'($urandom_range(0, 32'h1FF));
            drive_edge(f, b, ba);
            exp_v = {m_pc, m_ip, m_ii, m_iv};
            act_v = {instru_addr, id_pc, id_instru, id_valid};
            n_cmp++;
            if (act_v !== exp_v) begin
                n_err++;
                $display("FAIL random_step%0d (f=%b b=%b ba=%h): got %h expected %h",
                         i, f, b, ba, act_v, exp_v);
            end
        end
    endtask

    initial begin
        n_cmp        = 0;
        n_err        = 0;
        rst          = 1'b0;
        freeze       = 1'b0;
        branch_taken = 1'b0;
        branch_addr  = '0;
        for (int i = 0; i < 128; i++) mem[i] = $urandom();
        mem[0] = 32'hE3A00B01;
        mem[1] = 32'hE3A01A01;
        mem[5] = 32'h0;

        test_reset();
        test_run();
        test_freeze();
        test_branch();
        test_branch_freeze();
        test_wrap();
        test_async_reset();
        test_random();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
